// File: rtl/branch_predictor_gshare.sv
// rtl/branch_predictor_gshare.sv - gshare/bimodal branch predictor with saturating counters
module branch_predictor_gshare #(
    parameter int INDEX_W = 5,
    parameter int CTR_W   = 2,
    parameter int GHR_W   = 5,
    parameter int GSHARE  = 1,
    parameter int STAT_W  = 16
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               lk_valid,
    input  logic [INDEX_W-1:0] lk_idx,
    output logic               pred_valid,
    output logic               pred_taken,
    output logic [GHR_W-1:0]   pred_ghr,
    input  logic               upd_valid,
    input  logic [INDEX_W-1:0] upd_idx,
    input  logic [GHR_W-1:0]   upd_ghr,
    input  logic               upd_taken,
    input  logic               upd_pred,
    output logic [GHR_W-1:0]   ghr,
    output logic [STAT_W-1:0]  mispred_cnt
);

    localparam int               DEPTH    = 1 << INDEX_W;
    localparam logic [CTR_W-1:0] CTR_INIT = {1'b0, {(CTR_W-1){1'b1}}};
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

    logic [CTR_W-1:0]   ctr_q [DEPTH];
    logic [INDEX_W-1:0] lk_ghr_ext;
    logic [INDEX_W-1:0] upd_ghr_ext;
    logic [INDEX_W-1:0] lk_index;
    logic [INDEX_W-1:0] upd_index;
    logic [CTR_W-1:0]   upd_ctr_cur;
    logic [CTR_W-1:0]   upd_ctr_next;
    logic [CTR_W-1:0]   lk_ctr;
    logic [GHR_W-1:0]   ghr_next;

    // Zero-extend both history values to index width and form the table indices
    always_comb begin
        lk_ghr_ext                = '0;
        upd_ghr_ext               = '0;
        lk_ghr_ext[GHR_W-1:0]     = ghr;
        upd_ghr_ext[GHR_W-1:0]    = upd_ghr;
        if (GSHARE != 0) begin
            lk_index  = lk_idx ^ lk_ghr_ext;
            upd_index = upd_idx ^ upd_ghr_ext;
        end else begin
            lk_index  = lk_idx;
            upd_index = upd_idx;
        end
    end

    // Saturating counter step for the entry being trained
    always_comb begin
        upd_ctr_cur  = ctr_q[upd_index];
        upd_ctr_next = upd_ctr_cur;
        if (upd_taken) begin
            if (upd_ctr_cur != CTR_MAX) begin
                upd_ctr_next = upd_ctr_cur + 1'b1;
            end
        end else begin
            if (upd_ctr_cur != '0) begin
                upd_ctr_next = upd_ctr_cur - 1'b1;
            end
        end
    end

    // Write-through bypass: a lookup hitting the entry being trained sees the new value
    always_comb begin
        if (upd_valid && (upd_index == lk_index)) begin
            lk_ctr = upd_ctr_next;
        end else begin
            lk_ctr = ctr_q[lk_index];
        end
    end

    // Shift the resolved outcome into the history
    generate
        if (GHR_W == 1) begin : g_ghr_one
            assign ghr_next = upd_taken;
        end else begin : g_ghr_multi
            assign ghr_next = {ghr[GHR_W-2:0], upd_taken};
        end
    endgenerate

    // Counter table: reset to weakly-not-taken, train on resolved branches
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= CTR_INIT;
            end
        end else if (upd_valid) begin
            ctr_q[upd_index] <= upd_ctr_next;
        end
    end

    // Registered prediction; taken/ghr hold while no lookup is issued
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_ghr   <= '0;
        end else begin
            pred_valid <= lk_valid;
            if (lk_valid) begin
                pred_taken <= lk_ctr[CTR_W-1];
                pred_ghr   <= ghr;
            end
        end
    end

    // Non-speculative history and saturating misprediction count
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            ghr         <= '0;
            mispred_cnt <= '0;
        end else if (upd_valid) begin
            ghr <= ghr_next;
            if ((upd_pred != upd_taken) && (mispred_cnt != STAT_MAX)) begin
                mispred_cnt <= mispred_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// tb/tb_branch_predictor_gshare.sv - directed self-checking bench for branch_predictor_gshare
module tb_branch_predictor_gshare;

    logic       clk;
    logic       arst;
    logic       lk_valid;
    logic [4:0] lk_idx;
    logic       upd_valid;
    logic [4:0] upd_idx;
    logic [4:0] upd_ghr;
    logic       upd_taken;
    logic       upd_pred;

    logic        b_pred_valid, b_pred_taken;
    logic [4:0]  b_pred_ghr, b_ghr;
    logic [15:0] b_mispred;
    logic        g_pred_valid, g_pred_taken;
    logic [4:0]  g_pred_ghr, g_ghr;
    logic [15:0] g_mispred;
    logic        s_pred_valid, s_pred_taken;
    logic [4:0]  s_pred_ghr, s_ghr;
    logic [1:0]  s_mispred;

    int checks;
    int failures;

    branch_predictor_gshare #(.GSHARE(0)) u_bim (
        .clk(clk), .arst(arst), .lk_valid(lk_valid), .lk_idx(lk_idx),
        .pred_valid(b_pred_valid), .pred_taken(b_pred_taken), .pred_ghr(b_pred_ghr),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_ghr(upd_ghr),
        .upd_taken(upd_taken), .upd_pred(upd_pred), .ghr(b_ghr), .mispred_cnt(b_mispred)
    );

    branch_predictor_gshare #(.GSHARE(1)) u_gsh (
        .clk(clk), .arst(arst), .lk_valid(lk_valid), .lk_idx(lk_idx),
        .pred_valid(g_pred_valid), .pred_taken(g_pred_taken), .pred_ghr(g_pred_ghr),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_ghr(upd_ghr),
        .upd_taken(upd_taken), .upd_pred(upd_pred), .ghr(g_ghr), .mispred_cnt(g_mispred)
    );

    branch_predictor_gshare #(.GSHARE(0), .STAT_W(2)) u_st2 (
        .clk(clk), .arst(arst), .lk_valid(lk_valid), .lk_idx(lk_idx),
        .pred_valid(s_pred_valid), .pred_taken(s_pred_taken), .pred_ghr(s_pred_ghr),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_ghr(upd_ghr),
        .upd_taken(upd_taken), .upd_pred(upd_pred), .ghr(s_ghr), .mispred_cnt(s_mispred)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic lkv, input logic [4:0] lki, input logic updv,
                       input logic [4:0] updi, input logic [4:0] updg,
                       input logic updt, input logic updp);
        lk_valid  = lkv;
        lk_idx    = lki;
        upd_valid = updv;
        upd_idx   = updi;
        upd_ghr   = updg;
        upd_taken = updt;
        upd_pred  = updp;
        tick();
        lk_valid  = 1'b0;
        upd_valid = 1'b0;
    endtask

    task automatic lookup(input logic [4:0] idx);
        cyc(1'b1, idx, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic update(input logic [4:0] idx, input logic [4:0] g, input logic t, input logic p);
        cyc(1'b0, 5'd0, 1'b1, idx, g, t, p);
    endtask

    task automatic do_reset();
        arst = 1'b1;
        tick();
        #2;
        arst = 1'b0;
        tick();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        arst      = 1'b0;
        lk_valid  = 1'b0;
        lk_idx    = '0;
        upd_valid = 1'b0;
        upd_idx   = '0;
        upd_ghr   = '0;
        upd_taken = 1'b0;
        upd_pred  = 1'b0;
        #2;
        arst = 1'b1;
        #2;
        check("rst_pred_valid", b_pred_valid, 0);
        check("rst_pred_taken", b_pred_taken, 0);
        check("rst_pred_ghr", b_pred_ghr, 0);
        check("rst_ghr", b_ghr, 0);
        check("rst_mispred", b_mispred, 0);
        tick();
        #2;
        arst = 1'b0;
        tick();

        // First lookup after reset
        lookup(5'd3);
        check("lk3_valid", b_pred_valid, 1);
        check("lk3_taken", b_pred_taken, 0);
        check("lk3_ghr", b_pred_ghr, 0);
        tick();
        check("lk_idle_valid", b_pred_valid, 0);
        for (int i = 0; i < 32; i++) begin
            lookup(5'(i));
            check($sformatf("init_entry%0d", i), b_pred_taken, 0);
        end

        // Bimodal training on idx 7 including both saturation limits
        update(5'd7, 5'd0, 1'b1, 1'b1);
        update(5'd7, 5'd0, 1'b1, 1'b1);
        lookup(5'd7);
        check("tr7_11", b_pred_taken, 1);
        update(5'd7, 5'd0, 1'b1, 1'b1);
        update(5'd7, 5'd0, 1'b0, 1'b0);
        lookup(5'd7);
        check("tr7_top_sat", b_pred_taken, 1);
        update(5'd7, 5'd0, 1'b0, 1'b0);
        lookup(5'd7);
        check("tr7_01", b_pred_taken, 0);
        update(5'd7, 5'd0, 1'b0, 1'b0);
        update(5'd7, 5'd0, 1'b0, 1'b0);
        update(5'd7, 5'd0, 1'b1, 1'b1);
        lookup(5'd7);
        check("tr7_bot_sat", b_pred_taken, 0);
        update(5'd7, 5'd0, 1'b1, 1'b1);
        lookup(5'd7);
        check("tr7_10", b_pred_taken, 1);

        // Asynchronous reset mid-stream
        update(5'd30, 5'd0, 1'b1, 1'b0);
        check("pre_rst_mispred", b_mispred, 1);
        check("pre_rst_ghr", b_ghr, 5'b00111);
        lk_valid = 1'b1;
        lk_idx   = 5'd7;
        tick();
        lk_valid = 1'b0;
        check("pre_rst_valid", b_pred_valid, 1);
        arst = 1'b1;
        #1;
        check("async_valid", b_pred_valid, 0);
        check("async_taken", b_pred_taken, 0);
        check("async_ghr", b_ghr, 0);
        check("async_mispred", b_mispred, 0);
        #1;
        arst = 1'b0;
        tick();
        lookup(5'd7);
        check("post_rst_e7", b_pred_taken, 0);
        check("post_rst_ghr", b_ghr, 0);

        // Gshare indexing
        do_reset();
        update(5'd20, 5'd0, 1'b1, 1'b1);
        update(5'd20, 5'd0, 1'b1, 1'b1);
        update(5'd20, 5'd0, 1'b0, 1'b0);
        check("gs_ghr6", g_ghr, 5'b00110);
        lookup(5'd6);
        check("gs_lk6_taken", g_pred_taken, 0);
        check("gs_lk6_ghr", g_pred_ghr, 5'b00110);
        update(5'd6, 5'd6, 1'b1, 1'b1);
        check("gs_ghr13", g_ghr, 5'b01101);
        lookup(5'd13);
        check("gs_lk13_taken", g_pred_taken, 1);
        check("gs_lk13_ghr", g_pred_ghr, 5'b01101);
        check("bim_lk13_taken", b_pred_taken, 0);

        // Simultaneous lookup and update
        do_reset();
        cyc(1'b1, 5'd9, 1'b1, 5'd9, 5'd0, 1'b1, 1'b1);
        check("byp_bim_up", b_pred_taken, 1);
        check("byp_gsh_up", g_pred_taken, 1);
        check("byp_gsh_preghr", g_pred_ghr, 0);
        check("byp_gsh_ghr", g_ghr, 1);
        lookup(5'd9);
        check("byp_e9_10", b_pred_taken, 1);
        cyc(1'b1, 5'd11, 1'b1, 5'd12, 5'd0, 1'b1, 1'b1);
        check("nobyp_e11", b_pred_taken, 0);
        lookup(5'd12);
        check("nobyp_e12", b_pred_taken, 1);
        cyc(1'b1, 5'd9, 1'b1, 5'd9, 5'd0, 1'b0, 1'b0);
        check("byp_bim_down", b_pred_taken, 0);

        // Misprediction counting and saturation
        do_reset();
        for (int i = 0; i < 15; i++) begin
            logic t;
            t = (i % 2) == 1;
            update(5'(i), 5'd0, t, (i < 10) ? ~t : t);
            if (i == 2) check("st2_after3", s_mispred, 3);
            if (i == 4) check("st2_after5", s_mispred, 3);
        end
        check("mispred_10", b_mispred, 10);
        check("mispred_st2_sat", s_mispred, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
